pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter XLEN, default 32, PC datapath width in bits (legal range 16..64).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_2000, PC value loaded on reset.
REQ-003 SHALL provide parameter TRAP_VEC, default 32'h0000_01C0, PC target used for trap redirects.
REQ-004 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL provide port stall, input, 1, holds PC when 1.
REQ-007 SHALL provide port PC_Sel, input, 2, next-PC source: 0 = PC+4, 1 = ALU_Out (branch/jump), 2 = TRAP_VEC, 3 = reserved, treated as 0.
REQ-008 SHALL provide port ALU_Out, input, XLEN, branch/jump target from Stage 2.
REQ-009 SHALL provide port PC, output, XLEN, current fetch PC (registered).
REQ-010 SHALL provide port PC_4, output, XLEN, combinational PC + 4.
REQ-011 SHALL provide port redirect_pending, output, 1, registered flag: a redirect was captured during stall and is not yet applied.
REQ-012 SHALL provide port misalign, output, 1, registered misaligned-target flag (see Configuration).

Function
REQ-013 PC_4 SHALL equal PC + 4 modulo 2^XLEN; PC = 2^XLEN-4 gives PC_4 = 0, with no carry-out.
REQ-014 A live redirect SHALL mean PC_Sel = 1 or 2 in a cycle with reset_n = 1.
REQ-015 With stall = 0, PC SHALL load on the next edge, in priority order:
- live redirect target (ALU_Out or TRAP_VEC);
- else the pending target, if redirect_pending = 1;
- else PC_4.
REQ-016 Latency: a PC_Sel/ALU_Out value sampled at edge N SHALL be visible on PC after edge N; the path is single-cycle.
REQ-017 With stall = 0, redirect_pending SHALL clear on that edge, whether or not a live redirect was present.
REQ-018 With stall = 1, PC SHALL hold its value.
REQ-019 With stall = 1 and a live redirect, the block SHALL capture the target into the pending register and set redirect_pending.
REQ-020 Pending overwrite rule: a later live ALU redirect SHALL overwrite a pending ALU target; a pending TRAP target is sticky and SHALL NOT be overwritten by an ALU redirect; a later TRAP SHALL overwrite anything.
REQ-021 With stall = 1, PC_Sel = 0 and no live redirect, the pending state SHALL be unchanged.
REQ-022 The ALU_Out target SHALL have bits [1:0] forced to 0 before use when PC_ALIGN_CHECK_EN is undefined.

Reset
REQ-023 When reset_n = 0 at a rising edge, the block SHALL set PC = RESET_PC, redirect_pending = 0, pending target = 0, pending-is-trap = 0 and misalign = 0.
REQ-024 Reset SHALL override stall and any live redirect, including one arriving mid-stall; any pending redirect SHALL be discarded.
REQ-025 On the first edge with reset_n = 1 and stall = 0, PC SHALL advance from RESET_PC per REQ-015.

Configuration
REQ-026 Macro PC_ALIGN_CHECK_EN defined: an ALU redirect with ALU_Out[1:0] != 0 SHALL be replaced by a TRAP_VEC redirect, with the same stall/pending rules and treated as a trap.
REQ-027 Macro PC_ALIGN_CHECK_EN defined: misalign SHALL pulse 1 for exactly one cycle on the edge where that substitution is applied to PC or captured as pending.
REQ-028 Macro PC_ALIGN_CHECK_EN undefined: misalign SHALL be tied to 0 and REQ-022 SHALL apply.

Verification
REQ-029 Scenario, reset and increment: reset_n = 0 for 2 cycles, then stall = 0, PC_Sel = 0 -> PC = 0x2000, 0x2004, 0x2008; PC_4 always PC + 4.
REQ-030 Scenario, branch: at PC = 0x2008, PC_Sel = 1, ALU_Out = 0x3000 for one cycle -> next PC = 0x3000, then 0x3004.
REQ-031 Scenario, stall capture and trap stickiness: stall = 1, PC_Sel = 1 with ALU_Out = 0x4000, next cycle PC_Sel = 2, next cycle PC_Sel = 1 with ALU_Out = 0x5000, then stall = 0 with PC_Sel = 0 -> PC holds during stall, redirect_pending = 1, and PC = 0x01C0 after release.
REQ-032 Scenario, wrap: with XLEN = 32, force PC = 0xFFFF_FFFC via ALU redirect -> PC_4 = 0, and next PC = 0x0000_0000.
REQ-033 Scenario, reset mid-stall: pending redirect to 0x4000 outstanding, then reset_n = 0 for 1 cycle -> PC = 0x2000, redirect_pending = 0, and no jump to 0x4000 afterwards.
REQ-034 Scenario, misalign: PC_Sel = 1, ALU_Out = 0x3002 -> with the macro, PC = 0x01C0 and misalign is high for 1 cycle; without the macro, PC = 0x3000 and misalign = 0.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-PC bus between the pipeline control and pc_gen.
// The master drives stall / next-PC select / branch target.
// The slave (pc_gen) returns the fetch PC and its status flags.
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic [1:0]      PC_Sel;
   logic [XLEN-1:0] ALU_Out;
   logic [XLEN-1:0] PC;
   logic [XLEN-1:0] PC_4;
   logic            redirect_pending;
   logic            misalign;

   modport master (
      output stall, PC_Sel, ALU_Out,
      input  PC, PC_4, redirect_pending, misalign
   );

   modport slave (
      input  stall, PC_Sel, ALU_Out,
      output PC, PC_4, redirect_pending, misalign
   );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator.
// It has a single-cycle next-PC path with stall handling.
// A redirect that arrives during a stall is held in a pending register.
// When the stall releases, the held redirect is applied.
// A held trap target is sticky against later ALU redirects.
// Optional macro PC_ALIGN_CHECK_EN enables the misalignment check:
//   - a misaligned ALU target becomes a trap redirect;
//   - misalign pulses for one cycle when that substitution happens.
// With the macro undefined, ALU_Out[1:0] is cleared and misalign is held at 0.
module pc_gen #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_2000),
   parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_01C0)
) (
   input logic   clk,
   input logic   reset_n,
   pc_gen_if.slave bus
);

   // Clear the low two bits so that the target is word aligned.
   function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
      return t & ~XLEN'(3);
   endfunction

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pend_tgt_q;
   logic            pend_q;
   logic            pend_trap_q;
   logic            live_alu;
   logic            live_trap;
   logic            bad_align;
   logic [XLEN-1:0] live_target;
   logic [XLEN-1:0] pc_inc;

   assign pc_inc               = pc_q + XLEN'(4);
   assign bus.PC               = pc_q;
   assign bus.PC_4             = pc_inc;
   assign bus.redirect_pending = pend_q;

   // Decode this cycle's redirect request and its effective target.
   // PC_Sel = 3 is reserved and decodes as sequential.
   always_comb begin
      live_alu    = 1'b0;
      live_trap   = 1'b0;
      bad_align   = 1'b0;
      live_target = TRAP_VEC;
`ifdef PC_ALIGN_CHECK_EN
      bad_align   = (bus.PC_Sel == 2'd1) && (bus.ALU_Out[1:0] != 2'b00);
      live_trap   = (bus.PC_Sel == 2'd2) || bad_align;
      live_alu    = (bus.PC_Sel == 2'd1) && !bad_align;
      live_target = live_trap ? TRAP_VEC : bus.ALU_Out;
`else
      live_trap   = (bus.PC_Sel == 2'd2);
      live_alu    = (bus.PC_Sel == 2'd1);
      live_target = live_trap ? TRAP_VEC : align_target(bus.ALU_Out);
`endif
   end

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q;
   assign bus.misalign = misalign_q;

   // Pulse misalign on the edge where a misaligned target is applied or captured.
   // Reset takes priority over the pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) misalign_q <= 1'b0;
      else          misalign_q <= bad_align;
   end
`else
   assign bus.misalign = 1'b0;
`endif

   // PC register and pending-redirect state.
   // Reset overrides stall and any redirect.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q        <= RESET_PC;
         pend_q      <= 1'b0;
         pend_tgt_q  <= '0;
         pend_trap_q <= 1'b0;
      end else if (!bus.stall) begin
         // Priority: live redirect, then held redirect, then sequential.
         if (live_alu || live_trap) pc_q <= live_target;
         else if (pend_q)           pc_q <= pend_tgt_q;
         else                       pc_q <= pc_inc;
         pend_q      <= 1'b0;
         pend_trap_q <= 1'b0;
      end else begin
         // Stalled: PC holds.
         // A trap always overwrites the held target.
         if (live_trap) begin
            pend_q      <= 1'b1;
            pend_tgt_q  <= live_target;
            pend_trap_q <= 1'b1;
         // An ALU redirect overwrites anything except a held trap.
         end else if (live_alu && !(pend_q && pend_trap_q)) begin
            pend_q      <= 1'b1;
            pend_tgt_q  <= live_target;
            pend_trap_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen.
// Directed vectors with literal expectations are followed by a pseudo-random tail.
// An abstract per-cycle model is compared on every cycle after reset.
module tb_pc_gen;

   localparam int XLEN = 32;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   pc_gen_if #(.XLEN(XLEN)) bus ();

   pc_gen #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Abstract model state:
   //   m_rank = 0: nothing held
   //   m_rank = 1: ALU target held
   //   m_rank = 2: trap target held
   logic [31:0] m_pc;
   logic [31:0] m_tgt;
   int          m_rank;
   logic        m_mis;
   logic        m_ok = 1'b0;

   always @(posedge clk) begin
      int          rank;
      logic [31:0] tgt;
      logic        bad;
      rank = 0;
      tgt  = 32'h0;
      bad  = 1'b0;
      if (bus.PC_Sel == 2'd2) begin
         rank = 2;
         tgt  = 32'h1C0;
      end else if (bus.PC_Sel == 2'd1) begin
`ifdef PC_ALIGN_CHECK_EN
         if (bus.ALU_Out % 4 != 0) begin
            rank = 2;
            tgt  = 32'h1C0;
            bad  = 1'b1;
         end else begin
            rank = 1;
            tgt  = bus.ALU_Out;
         end
`else
         rank = 1;
         tgt  = (bus.ALU_Out / 4) * 4;
`endif
      end
      if (!reset_n) begin
         m_pc   <= 32'h2000;
         m_tgt  <= 32'h0;
         m_rank <= 0;
         m_mis  <= 1'b0;
         m_ok   <= 1'b1;
      end else begin
         m_mis <= bad;
         if (!bus.stall) begin
            m_pc   <= (rank != 0) ? tgt : (m_rank != 0) ? m_tgt : m_pc + 32'd4;
            m_rank <= 0;
         end else if (rank != 0 && rank >= m_rank) begin
            m_tgt  <= tgt;
            m_rank <= rank;
         end
      end
   end

   // Compare the DUT against the model on every falling edge after reset.
   always @(negedge clk) begin
      if (m_ok) begin
         check("model_pc",      bus.PC,                      m_pc);
         check("model_pc4",     bus.PC_4,                    m_pc + 32'd4);
         check("model_pending", {31'b0, bus.redirect_pending}, {31'b0, (m_rank != 0)});
         check("model_misalign",{31'b0, bus.misalign},        {31'b0, m_mis});
      end
   end

   // Drive one cycle of inputs, then return 1 ns after the active edge.
   task automatic apply(input logic rn, input logic st, input logic [1:0] sel, input logic [31:0] alu);
      reset_n     = rn;
      bus.stall   = st;
      bus.PC_Sel  = sel;
      bus.ALU_Out = alu;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.stall   = 1'b0;
      bus.PC_Sel  = 2'd0;
      bus.ALU_Out = 32'h0;

      // Reset and sequential increment.
      apply(1'b0, 1'b0, 2'd0, 32'h0);
      apply(1'b0, 1'b0, 2'd0, 32'h0);
      check("reset_pc",       bus.PC,                  32'h2000);
      check("reset_pending",  {31'b0, bus.redirect_pending}, 32'h0);
      check("reset_misalign", {31'b0, bus.misalign},  32'h0);
      apply(1'b1, 1'b0, 2'd0, 32'h0);
      check("inc1",           bus.PC,                  32'h2004);
      apply(1'b1, 1'b0, 2'd0, 32'h0);
      check("inc2",           bus.PC,                  32'h2008);
      check("inc2_pc4",       bus.PC_4,                32'h200C);

      // Branch.
      apply(1'b1, 1'b0, 2'd1, 32'h3000);
      check("branch",         bus.PC,                  32'h3000);
      apply(1'b1, 1'b0, 2'd0, 32'h0);
      check("branch_inc",     bus.PC,                  32'h3004);

      // Stall capture and trap stickiness.
      apply(1'b1, 1'b1, 2'd1, 32'h4000);
      check("stall_hold",     bus.PC,                  32'h3004);
      check("stall_pending",  {31'b0, bus.redirect_pending}, 32'h1);
      apply(1'b1, 1'b1, 2'd2, 32'h0);
      apply(1'b1, 1'b1, 2'd1, 32'h5000);
      check("stall_hold3",    bus.PC,                  32'h3004);
      apply(1'b1, 1'b0, 2'd0, 32'h0);
      check("sticky_trap",    bus.PC,                  32'h01C0);
      check("pending_clear",  {31'b0, bus.redirect_pending}, 32'h0);
      apply(1'b1, 1'b0, 2'd0, 32'h0);
      check("after_trap",     bus.PC,                  32'h01C4);

      // A later ALU redirect overwrites a held ALU redirect.
      apply(1'b1, 1'b1, 2'd1, 32'h4000);
      apply(1'b1, 1'b1, 2'd1, 32'h6000);
      apply(1'b1, 1'b0, 2'd0, 32'h0);
      check("alu_overwrite",  bus.PC,                  32'h6000);

      // A live redirect at release beats the held one.
      apply(1'b1, 1'b1, 2'd2, 32'h0);
      apply(1'b1, 1'b0, 2'd1, 32'h7000);
      check("live_over_pend", bus.PC,                  32'h7000);

      // Wrap-around at the top of the address space.
      apply(1'b1, 1'b0, 2'd1, 32'hFFFF_FFFC);
      check("wrap_pc",        bus.PC,                  32'hFFFF_FFFC);
      check("wrap_pc4",       bus.PC_4,                32'h0);
      apply(1'b1, 1'b0, 2'd0, 32'h0);
      check("wrap_next",      bus.PC,                  32'h0);

      // Reset while a redirect is held discards it.
      apply(1'b1, 1'b1, 2'd1, 32'h4000);
      apply(1'b0, 1'b1, 2'd1, 32'h4000);
      check("rst_mid_pc",     bus.PC,                  32'h2000);
      check("rst_mid_pend",   {31'b0, bus.redirect_pending}, 32'h0);
      apply(1'b1, 1'b0, 2'd0, 32'h0);
      check("rst_no_jump",    bus.PC,                  32'h2004);

      // Reserved select behaves as sequential.
      // A stall with no redirect holds PC.
      apply(1'b1, 1'b0, 2'd3, 32'h9000);
      check("sel3_seq",       bus.PC,                  32'h2008);
      apply(1'b1, 1'b1, 2'd0, 32'h0);
      check("stall_plain",    bus.PC,                  32'h2008);

      // Misaligned ALU target.
      apply(1'b1, 1'b0, 2'd1, 32'h3002);
`ifdef PC_ALIGN_CHECK_EN
      check("mis_pc",         bus.PC,                  32'h01C0);
      check("mis_flag",       {31'b0, bus.misalign},  32'h1);
`else
      check("mis_pc",         bus.PC,                  32'h3000);
      check("mis_flag",       {31'b0, bus.misalign},  32'h0);
`endif
      apply(1'b1, 1'b0, 2'd0, 32'h0);
      check("mis_pulse_end",  {31'b0, bus.misalign},  32'h0);

      // Pseudo-random tail, checked by the model only.
      for (int i = 0; i < 80; i++) begin
         apply(($urandom_range(0, 19) != 0), ($urandom_range(0, 2) == 0),
               2'($urandom_range(0, 3)), $urandom);
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
